// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the SDRAM controller.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 25
);
    logic              dl_req_i;
    logic [ADDR_W-1:0] dl_addr_i;
    logic [7:0]        dl_d_i;
    logic              dl_ack_o;

    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [7:0]        cpu_d_i;
    logic [7:0]        cpu_q_o;
    logic              cpu_ack_o;

    logic              cas_req_i;
    logic [ADDR_W-1:0] cas_addr_i;
    logic [7:0]        cas_q_o;
    logic              cas_ack_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_d_o;
    logic [7:0]        mem_q_i;
    logic              mem_ack_i;

    logic              busy_o;
    logic              err_o;

    modport slave (
        input  dl_req_i, dl_addr_i, dl_d_i,
        output dl_ack_o,
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_d_i,
        output cpu_q_o, cpu_ack_o,
        input  cas_req_i, cas_addr_i,
        output cas_q_o, cas_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_d_o,
        input  mem_q_i, mem_ack_i,
        output busy_o, err_o
    );

    modport master (
        output dl_req_i, dl_addr_i, dl_d_i,
        input  dl_ack_o,
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_d_i,
        input  cpu_q_o, cpu_ack_o,
        output cas_req_i, cas_addr_i,
        input  cas_q_o, cas_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_d_o,
        output mem_q_i, mem_ack_i,
        input  busy_o, err_o
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Fixed-priority arbiter (download > CPU > cassette) onto one 8-bit SDRAM port,
// with CAS anti-starvation. Define SDRAM_ARB_TIMEOUT_EN to enable the mem_ack timeout.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W       = 25,
    parameter int unsigned CAS_MAX_WAIT = 8,
    parameter int unsigned TIMEOUT      = 64
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    sdram_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CAS_MAX_WAIT + 1);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_DL,
        OWN_CPU,
        OWN_CAS
    } owner_t;

    state_t            r_state, w_state_nx;
    owner_t            r_owner, w_owner_nx;
    logic              r_we, w_we_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [7:0]        r_d, w_d_nx;
    logic [7:0]        r_cpu_q, w_cpu_q_nx;
    logic [7:0]        r_cas_q, w_cas_q_nx;
    logic [CNT_W-1:0]  r_cas_wait_cnt, w_cas_wait_cnt_nx;
    logic              w_cas_due;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nx;
    logic             r_err, w_err_nx;
`endif

    assign w_cas_due = (r_cas_wait_cnt == CNT_W'(CAS_MAX_WAIT));

    always_comb begin
        w_state_nx        = r_state;
        w_owner_nx        = r_owner;
        w_we_nx           = r_we;
        w_addr_nx         = r_addr;
        w_d_nx            = r_d;
        w_cpu_q_nx        = r_cpu_q;
        w_cas_q_nx        = r_cas_q;
        w_cas_wait_cnt_nx = r_cas_wait_cnt;
`ifdef SDRAM_ARB_TIMEOUT_EN
        w_tmo_cnt_nx      = r_tmo_cnt;
        w_err_nx          = r_err;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (!bus.cas_req_i) begin
                    w_cas_wait_cnt_nx = '0;
                end
                if (bus.dl_req_i) begin
                    w_owner_nx = OWN_DL;
                    w_we_nx    = 1'b1;
                    w_addr_nx  = bus.dl_addr_i;
                    w_d_nx     = bus.dl_d_i;
                    w_state_nx = ST_ISSUE;
                end else if (bus.cas_req_i && w_cas_due) begin
                    w_owner_nx        = OWN_CAS;
                    w_we_nx           = 1'b0;
                    w_addr_nx         = bus.cas_addr_i;
                    w_d_nx            = '0;
                    w_cas_wait_cnt_nx = '0;
                    w_state_nx        = ST_ISSUE;
                end else if (bus.cpu_req_i) begin
                    w_owner_nx = OWN_CPU;
                    w_we_nx    = bus.cpu_we_i;
                    w_addr_nx  = bus.cpu_addr_i;
                    w_d_nx     = bus.cpu_d_i;
                    w_state_nx = ST_ISSUE;
                    if (bus.cas_req_i && !w_cas_due) begin
                        w_cas_wait_cnt_nx = r_cas_wait_cnt + 1'b1;
                    end
                end else if (bus.cas_req_i) begin
                    w_owner_nx        = OWN_CAS;
                    w_we_nx           = 1'b0;
                    w_addr_nx         = bus.cas_addr_i;
                    w_d_nx            = '0;
                    w_cas_wait_cnt_nx = '0;
                    w_state_nx        = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                w_tmo_cnt_nx = (r_state == ST_ISSUE) ? '0 : r_tmo_cnt + 1'b1;
`endif
                if (r_state == ST_ISSUE) begin
                    w_state_nx = ST_WAIT;
                end
                // A controller ack in the ISSUE cycle completes the access just like one in WAIT.
                if (bus.mem_ack_i) begin
                    if (r_owner == OWN_CPU && !r_we) w_cpu_q_nx = bus.mem_q_i;
                    if (r_owner == OWN_CAS)          w_cas_q_nx = bus.mem_q_i;
                    w_state_nx = ST_DONE;
`ifdef SDRAM_ARB_TIMEOUT_EN
                end else if (r_state == ST_WAIT && r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    if (r_owner == OWN_CPU && !r_we) w_cpu_q_nx = 8'hFF;
                    if (r_owner == OWN_CAS)          w_cas_q_nx = 8'hFF;
                    w_err_nx   = 1'b1;
                    w_state_nx = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_DL;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_d            <= '0;
            r_cpu_q        <= '0;
            r_cas_q        <= '0;
            r_cas_wait_cnt <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            r_tmo_cnt      <= '0;
            r_err          <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nx;
            r_owner        <= w_owner_nx;
            r_we           <= w_we_nx;
            r_addr         <= w_addr_nx;
            r_d            <= w_d_nx;
            r_cpu_q        <= w_cpu_q_nx;
            r_cas_q        <= w_cas_q_nx;
            r_cas_wait_cnt <= w_cas_wait_cnt_nx;
`ifdef SDRAM_ARB_TIMEOUT_EN
            r_tmo_cnt      <= w_tmo_cnt_nx;
            r_err          <= w_err_nx;
`endif
        end
    end

    assign bus.mem_req_o  = (r_state == ST_ISSUE);
    assign bus.mem_we_o   = r_we;
    assign bus.mem_addr_o = r_addr;
    assign bus.mem_d_o    = r_d;
    assign bus.dl_ack_o   = (r_state == ST_DONE) && (r_owner == OWN_DL);
    assign bus.cpu_ack_o  = (r_state == ST_DONE) && (r_owner == OWN_CPU);
    assign bus.cas_ack_o  = (r_state == ST_DONE) && (r_owner == OWN_CAS);
    assign bus.cpu_q_o    = r_cpu_q;
    assign bus.cas_q_o    = r_cas_q;
    assign bus.busy_o     = (r_state != ST_IDLE);
`ifdef SDRAM_ARB_TIMEOUT_EN
    assign bus.err_o      = r_err;
`else
    assign bus.err_o      = 1'b0;
`endif
endmodule
